// File: rtl/mmio_bridge.sv
// Memory-mapped bridge: word addresses below MMIO_BASE go to the data RAM.
// A few registers above MMIO_BASE feed a TX FIFO toward a ready/valid device.
module mmio_bridge #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] MMIO_BASE = 32'h0000_1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [11:0] ram_addr,
  output logic [31:0] ram_data,
  output logic        ram_wren,
  input  logic [31:0] ram_q,
  output logic        dev_valid,
  output logic [31:0] dev_data,
  input  logic        dev_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   drops_q, drops_d;

  logic is_ram_s, is_tx_s, is_status_s, is_drops_s;
  logic push_s, pop_s, accept_s, drop_s, drops_clr_s;
  logic full_s, empty_s;

  // Address decode and handshake qualifiers
  always_comb begin
    is_ram_s    = (address_dmem < MMIO_BASE);
    is_tx_s     = (address_dmem == MMIO_BASE);
    is_status_s = (address_dmem == (MMIO_BASE + 32'd1));
    is_drops_s  = (address_dmem == (MMIO_BASE + 32'd2));
    empty_s     = (count_q == {CW{1'b0}});
    full_s      = (count_q == DEPTH_C);
    push_s      = wren && is_tx_s;
    pop_s       = !empty_s && dev_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle
    accept_s    = push_s && ((count_q < DEPTH_C) || pop_s);
    drop_s      = push_s && !accept_s;
    drops_clr_s = wren && is_drops_s;
  end

  assign ram_addr  = address_dmem[11:0];
  assign ram_data  = data;
  assign ram_wren  = wren && is_ram_s;
  assign dev_valid = !empty_s;
  assign dev_data  = mem_q[head_q];

  // Processor read mux
  always_comb begin
    q_dmem = 32'h0000_0000;
    if (is_ram_s) begin
      q_dmem = ram_q;
    end else if (is_status_s) begin
      q_dmem = {16'h0000, 8'(count_q), 6'b00_0000, full_s, empty_s};
    end else if (is_drops_s) begin
      q_dmem = {16'h0000, drops_q};
    end else begin
      q_dmem = 32'h0000_0000;
    end
  end

  // FIFO pointer, occupancy and drop-counter next state
  always_comb begin
    head_d = pop_s ? (head_q + AW'(1)) : head_q;
    tail_d = accept_s ? (tail_q + AW'(1)) : tail_q;
    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drops_clr_s) begin
      drops_d = drop_s ? 16'h0001 : 16'h0000;
    end else if (drop_s && (drops_q != 16'hFFFF)) begin
      drops_d = drops_q + 16'h0001;
    end else begin
      drops_d = drops_q;
    end
  end

  // Control state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drops_q <= 16'h0000;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drops_q <= drops_d;
    end
  end

  // FIFO storage; contents are not cleared by reset
  always_ff @(posedge clock) begin
    if (!reset && accept_s) begin
      mem_q[tail_q] <= data;
    end
  end

endmodule
